fib_iter_core: RTL

- Iterative Fibonacci engine; the responder side of the start/done handshake that the auto-checking benches drive.
- Accepts an index n on a rising edge of start and computes F(n) with one addition per clock, where F(0)=0 and F(1)=1.
- Presents F(n) on ans and holds done high until the next request.
- Sits behind any controller or bench that issues n/start and samples ans once done is high.

---
 rtl/fib_pkg.sv | 13 +
 rtl/fib_datapath.sv | 69 ++++++
 rtl/fib_iter_core.sv | 110 +++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the iterative Fibonacci engine: FSM encoding and default widths.
package fib_pkg;

    localparam int unsigned DEF_N_W   = 5;
    localparam int unsigned DEF_ANS_W = 121;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/fib_datapath.sv
// Fibonacci pair registers with sticky overflow tracking and an iteration down-counter.
module fib_datapath
    import fib_pkg::*;
#(
    parameter int unsigned N_W   = DEF_N_W,
    parameter int unsigned ANS_W = DEF_ANS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [N_W-1:0]   n_in,
    output logic [ANS_W-1:0] a,
    output logic             a_ovf,
    output logic             cnt_zero
);

    logic [ANS_W-1:0] a_q, a_d;
    logic [ANS_W-1:0] b_q, b_d;
    logic             a_ovf_q, a_ovf_d;
    logic             b_ovf_q, b_ovf_d;
    logic [N_W-1:0]   cnt_q, cnt_d;
    logic [ANS_W:0]   sum;

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        a_ovf_d = a_ovf_q;
        b_ovf_d = b_ovf_q;
        cnt_d   = cnt_q;
        if (load) begin
            a_d     = '0;
            b_d     = {{(ANS_W-1){1'b0}}, 1'b1};
            a_ovf_d = 1'b0;
            b_ovf_d = 1'b0;
            cnt_d   = n_in;
        end else if (step) begin
            // Overflow follows the value: a inherits b's flag, b collects both plus the carry.
            a_d     = b_q;
            b_d     = sum[ANS_W-1:0];
            a_ovf_d = b_ovf_q;
            b_ovf_d = a_ovf_q | b_ovf_q | sum[ANS_W];
            cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            a_ovf_q <= a_ovf_d;
            b_ovf_q <= b_ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign a        = a_q;
    assign a_ovf    = a_ovf_q;
    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/fib_iter_core.sv
// Iterative Fibonacci engine: start edge detection, control FSM and registered result outputs.
module fib_iter_core
    import fib_pkg::*;
#(
    parameter int unsigned N_W   = DEF_N_W,
    parameter int unsigned ANS_W = DEF_ANS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    output logic             busy,
    output logic             done,
    output logic [ANS_W-1:0] ans,
    output logic             ovf
);

    state_t           state_q, state_d;
    logic             start_q;
    logic             arm_q, arm_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [ANS_W-1:0] ans_q, ans_d;

    logic             accept;
    logic             dp_load;
    logic             dp_step;
    logic [ANS_W-1:0] dp_a;
    logic             dp_a_ovf;
    logic             dp_cnt_zero;

    // arm_q blocks a start that was already high across reset release until it has been seen low.
    assign accept = start & ~start_q & arm_q;
    assign arm_d  = arm_q | ~start;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        ans_d   = ans_q;
        dp_load = 1'b0;
        dp_step = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    ans_d   = '0;
                    dp_load = 1'b1;
                end
            end
            CALC: begin
                if (dp_cnt_zero) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ans_d   = dp_a;
                    ovf_d   = dp_a_ovf;
                end else begin
                    dp_step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            arm_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ans_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            arm_q   <= arm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            ans_q   <= ans_d;
        end
    end

    fib_datapath #(
        .N_W   (N_W),
        .ANS_W (ANS_W)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (dp_load),
        .step     (dp_step),
        .n_in     (n),
        .a        (dp_a),
        .a_ovf    (dp_a_ovf),
        .cnt_zero (dp_cnt_zero)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign ans  = ans_q;
    assign ovf  = ovf_q;

endmodule
